fetch_stage: RTL and testbench

Instruction-fetch stage of the Core Musa datapath. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents instruction, PC and next-PC (`_npc1`) to the downstream decode stage with a valid/ready handshake. Accepts PC redirects from execute (branch/jump) at any time and squashes in-flight fetches correctly.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction-fetch stage of the Core Musa datapath.
//           - Holds the program counter.
//           - Fetches one 32-bit word per instruction over an imem req/ack
//             handshake.
//           - Hands instruction, PC and PC+4 to decode over valid/ready.
//           - Redirects from execute are accepted at any time; a fetch that
//             is already on the bus is drained and its data discarded.
// Options : FETCH_MISALIGN_EN - a misaligned PC on entry to REQ traps into
//           HALT, which only reset can leave. When the macro is not defined,
//           the low PC bits are masked off the fetch address.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] _npc1,
    output logic [2:0]  stage,
    output logic        misalign
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_REQ    = 3'd1,
        ST_VALID  = 3'd2,
        ST_SQUASH = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

`ifdef FETCH_MISALIGN_EN
    // The full PC goes out on the bus; misalignment is trapped instead.
    localparam logic [31:0] C_ADDR_MASK = 32'hFFFF_FFFF;
`else
    // Word-aligned fetch; the low PC bits are still reported on if_pc.
    localparam logic [31:0] C_ADDR_MASK = 32'hFFFF_FFFC;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] instr_q, instr_d;

    // Every path back into REQ goes through one point. That point loads
    // the new PC, sets up the fetch address and does the optional
    // alignment check.
    logic        enter_req;
    logic [31:0] req_target;

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC & C_ADDR_MASK;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and next-datapath logic for the fetch controller.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        enter_req  = 1'b0;
        req_target = pc_q;

        case (state_q)
            ST_RST: begin
                enter_req  = 1'b1;
                req_target = pc_q;
            end

            ST_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_ack) begin
                        // The data belongs to the old path and is dropped.
                        // The bus is free, so the new target is fetched
                        // straight away.
                        enter_req  = 1'b1;
                        req_target = redirect_pc;
                    end else begin
                        // The request must stay on the bus until it is
                        // acked, so the ack is awaited in SQUASH.
                        state_d = ST_SQUASH;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end

            ST_SQUASH: begin
                // If several redirects arrive, the last one wins.
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    enter_req  = 1'b1;
                    req_target = redirect ? redirect_pc : pc_q;
                end
            end

            ST_VALID: begin
                // A redirect takes priority over decode accepting the
                // instruction.
                if (redirect) begin
                    enter_req  = 1'b1;
                    req_target = redirect_pc;
                end else if (dec_ready) begin
                    enter_req  = 1'b1;
                    req_target = pc_q + 32'd4;
                end
            end

            ST_HALT: begin
                // Parked until reset.
            end

            default: begin
                state_d = ST_RST;
            end
        endcase

        if (enter_req) begin
            pc_d    = req_target;
            addr_d  = req_target & C_ADDR_MASK;
            state_d = ST_REQ;
`ifdef FETCH_MISALIGN_EN
            if (req_target[1:0] != 2'b00) begin
                state_d = ST_HALT;
            end
`endif
        end
    end

    // All outputs are decoded from registered state only.
    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_SQUASH);
    assign imem_addr = addr_q;
    assign if_valid  = (state_q == ST_VALID);
    assign if_instr  = instr_q;
    assign if_pc     = pc_q;
    assign _npc1     = pc_q + 32'd4;
    assign stage     = state_q;

`ifdef FETCH_MISALIGN_EN
    assign misalign  = (state_q == ST_HALT);
`else
    assign misalign  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage.
//           - A per-cycle vector table covers the main flows: zero-wait
//             fetch, wait states, decode stall, squash, redirect priority
//             and PC wrap.
//           - Hand-written sequences cover misaligned redirect and an
//             asynchronous reset during a fetch.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] npc1;
    logic [2:0]  stage;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        ._npc1       (npc1),
        .stage       (stage),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [2:0]  e_stage;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ack, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic rdy, input logic e_req,
                       input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic [31:0] e_npc, input logic [2:0] e_stage);
        vec_t v;
        v = '{ack, rdata, redir, rpc, rdy, e_req, e_addr, e_valid, e_instr, e_pc, e_npc, e_stage};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic redir,
                         input logic [31:0] rpc, input logic rdy);
        imem_ack    = ack;
        imem_rdata  = rdata;
        redirect    = redir;
        redirect_pc = rpc;
        dec_ready   = rdy;
    endtask

    initial begin
        //   ack rdata          rd rpc            rdy | req addr          vld instr          pc             npc            stg
        add(0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 3'd0); // 0 RST
        add(1, 32'h2000_0001,  0, 32'h0,          1,  1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 3'd1); // 1 REQ ack
        add(0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0000, 1, 32'h2000_0001, 32'h0000_0000, 32'h0000_0004, 3'd2); // 2 VALID
        add(1, 32'h2000_0002,  0, 32'h0,          1,  1, 32'h0000_0004, 0, 32'h2000_0001, 32'h0000_0004, 32'h0000_0008, 3'd1); // 3 REQ ack
        add(0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 4 stall
        add(1, 32'hDEAD_BEEF,  0, 32'h0,          0,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 5 stray ack
        add(0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 6
        add(0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 7
        add(0, 32'h0,          0, 32'h0,          0,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 8
        add(0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0004, 1, 32'h2000_0002, 32'h0000_0004, 32'h0000_0008, 3'd2); // 9 accept
        add(0, 32'h0,          0, 32'h0,          0,  1, 32'h0000_0008, 0, 32'h2000_0002, 32'h0000_0008, 32'h0000_000C, 3'd1); // 10 wait
        add(0, 32'h0,          0, 32'h0,          0,  1, 32'h0000_0008, 0, 32'h2000_0002, 32'h0000_0008, 32'h0000_000C, 3'd1); // 11 wait
        add(0, 32'h0,          0, 32'h0,          0,  1, 32'h0000_0008, 0, 32'h2000_0002, 32'h0000_0008, 32'h0000_000C, 3'd1); // 12 wait
        add(1, 32'h3000_0003,  0, 32'h0,          0,  1, 32'h0000_0008, 0, 32'h2000_0002, 32'h0000_0008, 32'h0000_000C, 3'd1); // 13 ack
        add(0, 32'h0,          0, 32'h0,          1,  0, 32'h0000_0008, 1, 32'h3000_0003, 32'h0000_0008, 32'h0000_000C, 3'd2); // 14
        add(0, 32'h0,          1, 32'h0000_0100,  0,  1, 32'h0000_000C, 0, 32'h3000_0003, 32'h0000_000C, 32'h0000_0010, 3'd1); // 15 redirect
        add(0, 32'h0,          0, 32'h0,          0,  1, 32'h0000_000C, 0, 32'h3000_0003, 32'h0000_0100, 32'h0000_0104, 3'd3); // 16 SQUASH
        add(1, 32'hBAD0_BAD0,  0, 32'h0,          0,  1, 32'h0000_000C, 0, 32'h3000_0003, 32'h0000_0100, 32'h0000_0104, 3'd3); // 17 drop
        add(1, 32'h4000_0004,  0, 32'h0,          0,  1, 32'h0000_0100, 0, 32'h3000_0003, 32'h0000_0100, 32'h0000_0104, 3'd1); // 18
        add(0, 32'h0,          1, 32'hFFFF_FFFC,  1,  0, 32'h0000_0100, 1, 32'h4000_0004, 32'h0000_0100, 32'h0000_0104, 3'd2); // 19 redir+rdy
        add(1, 32'h5000_0005,  0, 32'h0,          0,  1, 32'hFFFF_FFFC, 0, 32'h4000_0004, 32'hFFFF_FFFC, 32'h0000_0000, 3'd1); // 20
        add(0, 32'h0,          0, 32'h0,          1,  0, 32'hFFFF_FFFC, 1, 32'h5000_0005, 32'hFFFF_FFFC, 32'h0000_0000, 3'd2); // 21 wrap
        add(1, 32'h6000_0006,  1, 32'h0000_0200,  0,  1, 32'h0000_0000, 0, 32'h5000_0005, 32'h0000_0000, 32'h0000_0004, 3'd1); // 22 redir+ack
        add(0, 32'h0,          1, 32'h0000_0300,  0,  1, 32'h0000_0200, 0, 32'h5000_0005, 32'h0000_0200, 32'h0000_0204, 3'd1); // 23 redir
        add(0, 32'h0,          1, 32'h0000_0400,  0,  1, 32'h0000_0200, 0, 32'h5000_0005, 32'h0000_0300, 32'h0000_0304, 3'd3); // 24 redir again
        add(1, 32'h7000_0007,  0, 32'h0,          0,  1, 32'h0000_0200, 0, 32'h5000_0005, 32'h0000_0400, 32'h0000_0404, 3'd3); // 25 drop
        add(1, 32'h8000_0008,  0, 32'h0,          0,  1, 32'h0000_0400, 0, 32'h5000_0005, 32'h0000_0400, 32'h0000_0404, 3'd1); // 26
        add(0, 32'h0,          1, 32'h0000_0102,  0,  0, 32'h0000_0400, 1, 32'h8000_0008, 32'h0000_0400, 32'h0000_0404, 3'd2); // 27 misaligned

        // Reset state, held for a couple of cycles.
        drive(0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst imem_req",  {31'b0, imem_req}, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0000_0000);
        chk("rst if_valid",  {31'b0, if_valid}, 32'h0);
        chk("rst if_instr",  if_instr, 32'h0);
        chk("rst if_pc",     if_pc, 32'h0000_0000);
        chk("rst npc1",      npc1, 32'h0000_0004);
        chk("rst stage",     {29'b0, stage}, 32'h0);
        chk("rst misalign",  {31'b0, misalign}, 32'h0);
        rst = 1'b1;

        // Table: inputs are applied, then the registered outputs are checked.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d imem_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d if_valid", i),  {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d if_instr", i),  if_instr, vecs[i].e_instr);
            chk($sformatf("v%0d if_pc", i),     if_pc, vecs[i].e_pc);
            chk($sformatf("v%0d npc1", i),      npc1, vecs[i].e_npc);
            chk($sformatf("v%0d stage", i),     {29'b0, stage}, {29'b0, vecs[i].e_stage});
            chk($sformatf("v%0d misalign", i),  {31'b0, misalign}, 32'h0);
            @(negedge clk);
        end

        // Effect of the misaligned redirect (0x102) from the last vector.
        drive(0, 32'h0, 0, 32'h0, 0);
        #1;
`ifdef FETCH_MISALIGN_EN
        chk("halt stage",    {29'b0, stage}, 32'h4);
        chk("halt misalign", {31'b0, misalign}, 32'h1);
        chk("halt imem_req", {31'b0, imem_req}, 32'h0);
        chk("halt if_valid", {31'b0, if_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h1234_5678, 1, 32'h0000_0200, 1);
            @(negedge clk);
            #1;
            chk($sformatf("halt%0d stage", k),    {29'b0, stage}, 32'h4);
            chk($sformatf("halt%0d imem_req", k), {31'b0, imem_req}, 32'h0);
            chk($sformatf("halt%0d misalign", k), {31'b0, misalign}, 32'h1);
        end
        drive(0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
`else
        chk("mis stage",     {29'b0, stage}, 32'h1);
        chk("mis imem_req",  {31'b0, imem_req}, 32'h1);
        chk("mis imem_addr", imem_addr, 32'h0000_0100);
        chk("mis if_pc",     if_pc, 32'h0000_0102);
        chk("mis npc1",      npc1, 32'h0000_0106);
        chk("mis misalign",  {31'b0, misalign}, 32'h0);
        drive(1, 32'h9000_0009, 0, 32'h0, 0);
        @(negedge clk);
        #1;
        chk("mis2 stage",    {29'b0, stage}, 32'h2);
        chk("mis2 if_instr", if_instr, 32'h9000_0009);
        chk("mis2 if_pc",    if_pc, 32'h0000_0102);
        drive(0, 32'h0, 0, 32'h0, 1);
        @(negedge clk);
        #1;
        chk("mis3 imem_addr", imem_addr, 32'h0000_0104);
        chk("mis3 if_pc",     if_pc, 32'h0000_0106);
        chk("mis3 imem_req",  {31'b0, imem_req}, 32'h1);
        drive(0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b0;
        #1;
        chk("arst imem_req",  {31'b0, imem_req}, 32'h0);
        chk("arst stage",     {29'b0, stage}, 32'h0);
        chk("arst if_pc",     if_pc, 32'h0);
        chk("arst imem_addr", imem_addr, 32'h0);
        chk("arst if_instr",  if_instr, 32'h0);
        chk("arst misalign",  {31'b0, misalign}, 32'h0);
        drive(1, 32'hAAAA_AAAA, 0, 32'h0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("late-ack stage",    {29'b0, stage}, 32'h0);
        chk("late-ack if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("post-rst stage",    {29'b0, stage}, 32'h1);
        chk("post-rst if_instr", if_instr, 32'h0);
        chk("post-rst addr",     imem_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("post-rst2 stage",    {29'b0, stage}, 32'h2);
        chk("post-rst2 if_instr", if_instr, 32'hAAAA_AAAA);
        chk("post-rst2 if_pc",    if_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
